// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: control logic for a BCD stopwatch.
//   Conditions three raw push-buttons (two-flop synchronizer, then debounce),
//   turns their debounced rising edges into start/lap/clear events and walks an
//   IDLE/RUN/STOP/LAP state machine.  The external timer is held in clear
//   while IDLE and is toggled between counting and stopped by single-cycle
//   pause pulses that are spaced at least GAP cycles apart.
// Ports:
//   clock        in   system clock, posedge
//   rst          in   synchronous active-low reset
//   btn_start    in   raw start/stop button, active-high
//   btn_lap      in   raw lap button, active-high
//   btn_clear    in   raw clear button, active-high
//   elapsed_in   in   live BCD count from the timer (4*NUMCELLS bits)
//   timer_clr    out  hold-clear to the timer (high in IDLE)
//   timer_pause  out  one-cycle run/stop toggle pulse to the timer
//   display      out  lap register in LAP, elapsed_in otherwise
//   lap_count    out  laps since last clear, saturating at 15
//   state        out  IDLE=00 RUN=01 STOP=10 LAP=11
module stopwatch_ctrl #(
  parameter int CLOCKSPEED  = 10000000,
  parameter int NUMCELLS    = 4,
  parameter int DEBOUNCE_MS = 10
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic                    btn_start,
  input  logic                    btn_lap,
  input  logic                    btn_clear,
  input  logic [4*NUMCELLS-1:0]   elapsed_in,
  output logic                    timer_clr,
  output logic                    timer_pause,
  output logic [4*NUMCELLS-1:0]   display,
  output logic [3:0]              lap_count,
  output logic [1:0]              state
);

  localparam int DB  = CLOCKSPEED / 1000 * DEBOUNCE_MS;
  localparam int GAP = CLOCKSPEED / 1000 + 2;
  localparam int DW  = 4 * NUMCELLS;
  localparam int DBW = $clog2(DB + 1);
  localparam int GW  = $clog2(GAP + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB - 1);
  localparam logic [GW-1:0]  GAP_V   = GW'(GAP);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STOP = 2'b10,
    ST_LAP  = 2'b11
  } state_t;

  // Button bit order everywhere: [0]=start, [1]=lap, [2]=clear
  logic [2:0]     raw_s;
  logic [2:0]     sync1_q, sync2_q;
  logic [2:0]     level_q, level_d;
  logic [DBW-1:0] cnt_q [3];
  logic [DBW-1:0] cnt_d [3];
  logic [2:0]     press_q, press_d;

  state_t         state_q, state_d;
  logic [DW-1:0]  lap_q, lap_d;
  logic [3:0]     lap_count_q, lap_count_d;
  logic           timer_clr_q, timer_clr_d;
  logic           timer_pause_q, timer_pause_d;
  logic           pend_q, pend_d;
  logic [GW-1:0]  gap_q, gap_d;

  logic           ev_start_s, ev_lap_s, ev_clear_s;
  logic           pause_req_s;
  logic           eligible_s;

  assign raw_s = {btn_clear, btn_lap, btn_start};

  // A single event survives per cycle: clear beats start beats lap
  assign ev_clear_s = press_q[2];
  assign ev_start_s = press_q[0] & ~press_q[2];
  assign ev_lap_s   = press_q[1] & ~press_q[2] & ~press_q[0];

  // Debounce: count consecutive cycles the synchronized input differs from the level
  always_comb begin
    level_d = level_q;
    press_d = 3'b000;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = {DBW{1'b0}};
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          // DB-th consecutive differing sample: adopt it; only a rise is an event
          level_d[i] = sync2_q[i];
          press_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DBW'(1);
        end
      end else begin
        cnt_d[i] = {DBW{1'b0}};
      end
    end
  end

  // Stopwatch state machine: next state, lap capture, pause requests
  always_comb begin
    state_d     = state_q;
    lap_d       = lap_q;
    lap_count_d = lap_count_q;
    pause_req_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ev_start_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (ev_start_s) begin
          state_d     = ST_STOP;
          pause_req_s = 1'b1;
        end else if (ev_lap_s) begin
          state_d = ST_LAP;
          lap_d   = elapsed_in;
          if (lap_count_q != 4'd15) begin
            lap_count_d = lap_count_q + 4'd1;
          end else begin
            lap_count_d = lap_count_q;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_LAP: begin
        if (ev_start_s) begin
          state_d     = ST_STOP;
          pause_req_s = 1'b1;
        end else if (ev_lap_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_LAP;
        end
      end
      ST_STOP: begin
        if (ev_clear_s) begin
          // Timer is stopped; toggling it back to counting while clear holds it
          // keeps its run phase consistent for the next start.
          state_d     = ST_IDLE;
          pause_req_s = 1'b1;
          lap_count_d = 4'd0;
          lap_d       = {DW{1'b0}};
        end else if (ev_start_s) begin
          state_d     = ST_RUN;
          pause_req_s = 1'b1;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    timer_clr_d = (state_d == ST_IDLE);
  end

  // Pause pacing: defer requests until GAP cycles after the previous pulse
  always_comb begin
    eligible_s    = (gap_q >= GAP_V);
    pend_d        = pend_q;
    timer_pause_d = 1'b0;
    if (pend_q) begin
      if (pause_req_s) begin
        // Two outstanding toggles cancel each other
        pend_d = 1'b0;
      end else if (eligible_s) begin
        timer_pause_d = 1'b1;
        pend_d        = 1'b0;
      end else begin
        pend_d = 1'b1;
      end
    end else if (pause_req_s) begin
      if (eligible_s) begin
        timer_pause_d = 1'b1;
      end else begin
        pend_d = 1'b1;
      end
    end else begin
      pend_d = 1'b0;
    end
    // gap_q reads 1 in the pulse cycle, so GAP means GAP cycles edge to edge
    if (timer_pause_d) begin
      gap_d = GW'(1);
    end else if (gap_q < GAP_V) begin
      gap_d = gap_q + GW'(1);
    end else begin
      gap_d = gap_q;
    end
  end

  // All state registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!rst) begin
      sync1_q       <= 3'b000;
      sync2_q       <= 3'b000;
      level_q       <= 3'b000;
      press_q       <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= {DBW{1'b0}};
      end
      state_q       <= ST_IDLE;
      lap_q         <= {DW{1'b0}};
      lap_count_q   <= 4'd0;
      timer_clr_q   <= 1'b1;
      timer_pause_q <= 1'b0;
      pend_q        <= 1'b0;
      gap_q         <= GAP_V;
    end else begin
      sync1_q       <= raw_s;
      sync2_q       <= sync1_q;
      level_q       <= level_d;
      press_q       <= press_d;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      state_q       <= state_d;
      lap_q         <= lap_d;
      lap_count_q   <= lap_count_d;
      timer_clr_q   <= timer_clr_d;
      timer_pause_q <= timer_pause_d;
      pend_q        <= pend_d;
      gap_q         <= gap_d;
    end
  end

  assign timer_clr   = timer_clr_q;
  assign timer_pause = timer_pause_q;
  assign lap_count   = lap_count_q;
  assign state       = state_q;
  assign display     = (state_q == ST_LAP) ? lap_q : elapsed_in;

endmodule
